// File: rtl/pb_conditioner.sv
// pb_conditioner: synchronises, debounces and edge-detects the Basys3 pushbuttons,
// then turns the four direction buttons into a single auto-repeating move command.
module pb_conditioner #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 15_000_000
) (
    input  logic       basys_clock,
    input  logic       reset_n,
    input  logic [4:0] pb,
    input  logic       enable,
    output logic [4:0] pb_db,
    output logic [4:0] pb_press,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       select_pulse
);
    localparam int DW   = $clog2(DEB_CYCLES) + 1;
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, PERIOD} state_e;

    logic [4:0]    sync1_q, sync2_q, db_q, db_d, press_q, press_d;
    logic [DW-1:0] deb_cnt_q [5];
    logic [DW-1:0] deb_cnt_d [5];
    state_e        state_q, state_d;
    logic [1:0]    dir_q, dir_d, new_dir;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          mv_q, mv_d, sel_q, sel_d, new_press, held;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) db_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
        press_d = db_d & ~db_q;
    end

    // The FSM looks at the debouncer's next state so the move lands in the same cycle as pb_press
    assign new_press = |press_d[4:1];
    assign new_dir   = press_d[1] ? 2'd0 : press_d[4] ? 2'd3 : press_d[2] ? 2'd1 : 2'd2;
    assign held      = db_d[3'(dir_q) + 3'd1];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rpt_d   = rpt_q;
        mv_d    = 1'b0;
        sel_d   = press_d[0] & enable;
        if (!enable) begin
            state_d = IDLE;
            rpt_d   = '0;
        end else if (new_press) begin
            state_d = DELAY;
            dir_d   = new_dir;
            rpt_d   = '0;
            mv_d    = 1'b1;
        end else if (state_q != IDLE) begin
            if (!held) begin
                state_d = IDLE;
                rpt_d   = '0;
            end else if (rpt_q == (state_q == DELAY ? DLY_LAST : PER_LAST)) begin
                state_d = PERIOD;
                rpt_d   = '0;
                mv_d    = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            press_q   <= '0;
            deb_cnt_q <= '{default: '0};
            state_q   <= IDLE;
            dir_q     <= '0;
            rpt_q     <= '0;
            mv_q      <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            sync1_q   <= pb;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_q     <= rpt_d;
            mv_q      <= mv_d;
            sel_q     <= sel_d;
        end
    end

    assign pb_db        = db_q;
    assign pb_press     = press_q;
    assign move_valid   = mv_q;
    assign move_dir     = dir_q;
    assign select_pulse = sel_q;
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: vector table, hand-written corner sequences and a randomized run,
// all cross-checked every cycle against a timeline-based reference model.
module tb_pb_conditioner;
    localparam int DEB = 4, RD = 20, RP = 8;

    logic       basys_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] pb = '0;
    logic [4:0] pb_db, pb_press;
    logic       move_valid, select_pulse;
    logic [1:0] move_dir;

    pb_conditioner #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .basys_clock(basys_clock), .reset_n(reset_n), .pb(pb), .enable(enable),
        .pb_db(pb_db), .pb_press(pb_press), .move_valid(move_valid),
        .move_dir(move_dir), .select_pulse(select_pulse)
    );

    always #5 basys_clock = ~basys_clock;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: pins reach the debouncer two edges late, a button flips after DEB
    // consecutive disagreeing samples, repeats are scheduled from the age of the active press.
    logic [4:0] hist [$];
    logic [4:0] m_db, m_press;
    int         m_run [5];
    logic       m_mv, m_sel, m_active;
    logic [1:0] m_dir;
    int         m_age;

    always @(posedge basys_clock or negedge reset_n) begin
        if (!reset_n) begin
            hist = '{5'd0, 5'd0};
            m_db = '0; m_press = '0; m_mv = 0; m_sel = 0; m_active = 0; m_dir = 0; m_age = 0;
            foreach (m_run[i]) m_run[i] = 0;
        end else begin
            logic [4:0] s, prev;
            s = hist.pop_front();
            hist.push_back(pb);
            prev = m_db;
            for (int i = 0; i < 5; i++) begin
                if (s[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_db[i] = s[i];
                        m_run[i] = 0;
                    end
                end else m_run[i] = 0;
            end
            m_press = m_db & ~prev;
            m_sel = m_press[0] & enable;
            m_mv = 0;
            if (!enable) m_active = 0;
            else if (|m_press[4:1]) begin
                m_active = 1;
                m_age = 0;
                m_mv = 1;
                m_dir = m_press[1] ? 2'd0 : m_press[4] ? 2'd3 : m_press[2] ? 2'd1 : 2'd2;
            end else if (m_active) begin
                if (!m_db[int'(m_dir) + 1]) m_active = 0;
                else begin
                    m_age++;
                    m_mv = (m_age == RD) || (m_age > RD && (m_age - RD) % RP == 0);
                end
            end
        end
    end

    always @(negedge basys_clock) begin
        chk("model pb_db", pb_db, m_db);
        chk("model pb_press", pb_press, m_press);
        chk("model move_valid", move_valid, m_mv);
        chk("model select_pulse", select_pulse, m_sel);
        if (m_mv) chk("model move_dir", move_dir, m_dir);
    end

    typedef struct {
        logic [4:0] p;
        logic       en;
        int         h;
        int         moves;
        int         dir;
        int         sels;
        int         presses;
    } vec_t;
    vec_t tbl [12];

    task automatic run(input logic [4:0] p, input logic e, input int h,
                       output int moves, output int last_dir, output int sels,
                       output int presses, output int coinc_bad);
        moves = 0; last_dir = -1; sels = 0; presses = 0; coinc_bad = 0;
        pb = p;
        enable = e;
        for (int k = 1; k <= h + 14; k++) begin
            @(negedge basys_clock);
            moves += int'(move_valid);
            if (move_valid) last_dir = int'(move_dir);
            sels += int'(select_pulse);
            presses += $countones(pb_press);
            if (select_pulse && !pb_press[0]) coinc_bad++;
            if (k == h) pb = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int moves, last_dir, sels, presses, coinc, first, bad_dir, late;
        int pk [$];
        int pd [$];
        tbl = '{
            '{5'b00010, 1'b1,  3, 0, -1, 0, 0},
            '{5'b00100, 1'b1, 60, 6,  1, 0, 1},
            '{5'b00010, 1'b1, 10, 1,  0, 0, 1},
            '{5'b01000, 1'b1, 21, 2,  2, 0, 1},
            '{5'b10000, 1'b1, 20, 1,  3, 0, 1},
            '{5'b11000, 1'b1, 30, 3,  3, 0, 2},
            '{5'b11110, 1'b1,  5, 1,  0, 0, 4},
            '{5'b01100, 1'b1,  5, 1,  1, 0, 2},
            '{5'b00001, 1'b1,  5, 0, -1, 1, 1},
            '{5'b00001, 1'b0,  5, 0, -1, 0, 1},
            '{5'b00010, 1'b0, 30, 0, -1, 0, 1},
            '{5'b00010, 1'b1,  4, 1,  0, 0, 1}
        };
        repeat (3) @(negedge basys_clock);
        chk("reset pb_db", pb_db, 0);
        chk("reset pb_press", pb_press, 0);
        chk("reset move_valid", move_valid, 0);
        chk("reset move_dir", move_dir, 0);
        chk("reset select_pulse", select_pulse, 0);
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge basys_clock);

        foreach (tbl[i]) begin
            run(tbl[i].p, tbl[i].en, tbl[i].h, moves, last_dir, sels, presses, coinc);
            chk($sformatf("vec%0d moves", i), moves, tbl[i].moves);
            chk($sformatf("vec%0d dir", i), last_dir, tbl[i].dir);
            chk($sformatf("vec%0d selects", i), sels, tbl[i].sels);
            chk($sformatf("vec%0d presses", i), presses, tbl[i].presses);
            chk($sformatf("vec%0d select/press coincidence", i), coinc, 0);
        end

        // Takeover: left pressed right after up's first repeat
        enable = 1'b1;
        pb = 5'b00010;
        for (int k = 1; k <= 55; k++) begin
            @(negedge basys_clock);
            if (move_valid) begin
                pk.push_back(k);
                pd.push_back(int'(move_dir));
            end
            if (k == 26) pb = 5'b00110;
        end
        chk("takeover pulse count", pk.size(), 4);
        if (pk.size() == 4) begin
            chk("takeover t0", pk[0], 6);  chk("takeover d0", pd[0], 0);
            chk("takeover t1", pk[1], 26); chk("takeover d1", pd[1], 0);
            chk("takeover t2", pk[2], 32); chk("takeover d2", pd[2], 1);
            chk("takeover t3", pk[3], 52); chk("takeover d3", pd[3], 1);
        end
        pb = '0;
        repeat (14) @(negedge basys_clock);

        // Simultaneous right+down, then down released while right stays held
        pb = 5'b11000;
        moves = 0; bad_dir = 0; late = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge basys_clock);
            moves += int'(move_valid);
            if (move_valid && move_dir != 2'd3) bad_dir++;
            if (move_valid && k >= 36) late++;
            if (k == 30) pb = 5'b01000;
        end
        chk("simul moves", moves, 3);
        chk("simul non-down moves", bad_dir, 0);
        chk("simul moves after down release", late, 0);
        pb = '0;
        repeat (14) @(negedge basys_clock);

        // Enable raised mid-hold: no move until a fresh press
        enable = 1'b0;
        pb = 5'b00010;
        moves = 0; presses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge basys_clock);
            moves += int'(move_valid);
            presses += int'(pb_press[1]);
            if (k == 15) enable = 1'b1;
        end
        chk("enable-late moves", moves, 0);
        chk("enable-late presses", presses, 1);
        pb = '0;
        repeat (14) @(negedge basys_clock);

        // Reset asserted during a repeat pulse, button still held afterwards
        pb = 5'b00100;
        repeat (26) @(negedge basys_clock);
        chk("pre-reset repeat", move_valid, 1);
        #2 reset_n = 1'b0;
        #1 chk("async reset outputs", {pb_db, pb_press, move_valid, move_dir, select_pulse}, 0);
        @(negedge basys_clock);
        reset_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge basys_clock);
            if (move_valid && first < 0) first = k;
        end
        chk("post-reset first move", first, 6);
        pb = '0;
        repeat (14) @(negedge basys_clock);

        for (int s = 0; s < 100; s++) begin
            pb = 5'($urandom_range(0, 31));
            enable = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 45)) @(negedge basys_clock);
        end
        pb = '0;
        enable = 1'b1;
        repeat (14) @(negedge basys_clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
